// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, widths and access-check helper for the data-memory responder
package dmem_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // True when the byte address is word aligned and lies inside [base, base+span)
  function automatic logic access_ok(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [32:0] span);
    logic [32:0] off;
    off = {1'b0, addr} - {1'b0, base};
    return (addr[1:0] == 2'b00) && (addr >= base) && (off < span);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word RAM with byte-enable writes and a registered read port
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [BE_W-1:0]   be_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_q;

  // One access per enable: byte-masked write, or capture of the whole word for a read
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency load/store responder for the MEM stage
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);
  localparam logic [32:0] SPAN   = 33'(DEPTH_WORDS) << 2;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic        rdata_sel_q;

  logic          accept_d;
  logic          enter_resp_d;
  logic          acc_write_d;
  logic [31:0]   acc_addr_d;
  logic [31:0]   acc_wdata_d;
  logic [3:0]    acc_be_d;
  logic          acc_ok_d;
  logic [AW-1:0] acc_idx_d;
  logic          ram_en_d;
  logic [31:0]   ram_rdata;

  // With LATENCY==1 the accept edge is also the RAM-access edge, so the live request is used
  always_comb begin
    accept_d     = (state_q == ST_IDLE) && req_valid;
    enter_resp_d = (accept_d && (LATENCY == 1)) || ((state_q == ST_WAIT) && (cnt_q == 4'd1));
    acc_write_d  = (state_q == ST_IDLE) ? req_write : write_q;
    acc_addr_d   = (state_q == ST_IDLE) ? req_addr  : addr_q;
    acc_wdata_d  = (state_q == ST_IDLE) ? req_wdata : wdata_q;
    acc_be_d     = (state_q == ST_IDLE) ? req_be    : be_q;
    acc_ok_d     = access_ok(acc_addr_d, BASE_ADDR, SPAN);
    acc_idx_d    = AW'((acc_addr_d - BASE_ADDR) >> 2);
    ram_en_d     = enter_resp_d && acc_ok_d && !rst;
  end

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk_i   (clk),
    .en_i    (ram_en_d),
    .we_i    (acc_write_d),
    .addr_i  (acc_idx_d),
    .wdata_i (acc_wdata_d),
    .be_i    (acc_be_d),
    .rdata_o (ram_rdata)
  );

  // Request/response FSM with registered handshake and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      be_q         <= 4'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_sel_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            write_q     <= req_write;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            be_q        <= req_be;
            cnt_q       <= LAT_M1;
            req_ready_q <= 1'b0;
            if (enter_resp_d) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= !acc_ok_d;
              rdata_sel_q  <= acc_ok_d && !acc_write_d;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (enter_resp_d) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= !acc_ok_d;
            rdata_sel_q  <= acc_ok_d && !acc_write_d;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rdata_sel_q  <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          rdata_sel_q  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = rdata_sel_q ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder at LATENCY 2 and 1
module tb_dmem_responder;

  logic             clk;
  logic [1:0]       rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_write;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0][3:0]  req_be;
  logic [1:0]       resp_valid;
  logic [1:0]       resp_ready;
  logic [1:0][31:0] resp_rdata;
  logic [1:0]       resp_err;

  int n_checks = 0;
  int n_fail   = 0;
  int lat [2]  = '{2, 1};
  logic [31:0] mm [2][256];

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .BASE_ADDR(32'h0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_be(req_be[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1), .BASE_ADDR(32'h0)) u_dut1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_be(req_be[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic m_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < 32'h400);
  endfunction

  task automatic txn(input int d, input logic wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     input int stall, output longint t_acc);
    logic        ok;
    logic [31:0] exp_rd;
    int          k;
    ok     = m_ok(addr);
    exp_rd = (ok && !wr) ? mm[d][addr[9:2]] : 32'd0;
    check("idle_ready", 32'(req_ready[d]), 32'd1);
    req_valid[d]  = 1'b1;
    req_write[d]  = wr;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    req_be[d]     = be;
    resp_ready[d] = (stall == 0);
    @(posedge clk);
    t_acc = longint'($time);
    #1;
    req_valid[d] = 1'b0;
    check("ready_drop", 32'(req_ready[d]), 32'd0);
    k = 1;
    while (!resp_valid[d] && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("latency", 32'(k), 32'(lat[d]));
    check("rdata", resp_rdata[d], exp_rd);
    check("err", 32'(resp_err[d]), 32'(!ok));
    for (int i = 0; i < stall; i++) begin
      req_valid[d] = 1'b1;
      req_addr[d]  = $urandom & 32'h3FC;
      @(posedge clk);
      #1;
      req_valid[d] = 1'b0;
      check("stall_valid", 32'(resp_valid[d]), 32'd1);
      check("stall_rdata", resp_rdata[d], exp_rd);
      check("stall_err", 32'(resp_err[d]), 32'(!ok));
      check("stall_ready", 32'(req_ready[d]), 32'd0);
    end
    resp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    check("done_valid", 32'(resp_valid[d]), 32'd0);
    check("done_rdata", resp_rdata[d], 32'd0);
    check("done_err", 32'(resp_err[d]), 32'd0);
    if (wr && ok) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mm[d][addr[9:2]][8*b +: 8] = wdata[8*b +: 8];
    end
  endtask

  task automatic go(input int d, input logic wr, input logic [31:0] addr,
                    input logic [31:0] wdata, input logic [3:0] be, input int stall);
    longint t;
    txn(d, wr, addr, wdata, be, stall, t);
  endtask

  task automatic check_idle_outputs(input int d);
    check("rst_ready", 32'(req_ready[d]), 32'd1);
    check("rst_valid", 32'(resp_valid[d]), 32'd0);
    check("rst_rdata", resp_rdata[d], 32'd0);
    check("rst_err", 32'(resp_err[d]), 32'd0);
  endtask

  initial begin
    longint t1, t2;
    logic [31:0] a;
    int sel;
    rst        = 2'b11;
    req_valid  = 2'b00;
    req_write  = 2'b00;
    req_addr   = '0;
    req_wdata  = '0;
    req_be     = '0;
    resp_ready = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs(0);
    check_idle_outputs(1);
    @(negedge clk);
    rst = 2'b00;
    @(posedge clk);
    #1;

    go(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    go(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
    go(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, 0);
    go(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
    check("merged_word", mm[0][4], 32'hDEADBEAA);
    go(0, 1'b1, 32'h3FC, 32'h5A5AC3C3, 4'hF, 0);
    go(0, 1'b0, 32'h12, 32'h0, 4'h0, 0);
    go(0, 1'b0, 32'h3FC, 32'h0, 4'h0, 0);
    go(0, 1'b1, 32'h400, 32'h11112222, 4'hF, 0);
    go(0, 1'b0, 32'h3FC, 32'h0, 4'h0, 0);
    go(0, 1'b1, 32'h3FE, 32'h33334444, 4'hF, 0);
    go(0, 1'b0, 32'h3FC, 32'h0, 4'h0, 0);
    go(0, 1'b1, 32'h10, 32'h77777777, 4'b0000, 0);
    go(0, 1'b0, 32'h10, 32'h0, 4'h0, 5);

    go(0, 1'b1, 32'h20, 32'h12345678, 4'hF, 0);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 32'h20;
    req_wdata[0] = 32'hFFFFFFFF;
    req_be[0]    = 4'hF;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    rst[0] = 1'b1;
    #1;
    check_idle_outputs(0);
    @(negedge clk);
    rst[0] = 1'b0;
    @(posedge clk);
    #1;
    go(0, 1'b0, 32'h20, 32'h0, 4'h0, 0);

    txn(1, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 0, t1);
    txn(1, 1'b0, 32'h30, 32'h0, 4'h0, 0, t2);
    check("accept_period", 32'(t2 - t1), 32'd20);

    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++) go(d, 1'b1, 32'(w * 4), $urandom, 4'hF, 0);
      go(d, 1'b1, 32'h3FC, $urandom, 4'hF, 0);
    end

    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 6)      a = 32'($urandom_range(0, 15)) * 4;
      else if (sel == 7) a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
      else if (sel == 8) a = 32'h400 + (32'($urandom_range(0, 4095)) << 2);
      else               a = 32'h3FC;
      go(n % 2, 1'($urandom), a, $urandom, 4'($urandom), ($urandom_range(0, 3) == 0) ? 2 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
